// File: rtl/poly_div2k_pkg.sv
// rtl/poly_div2k_pkg.sv - shared defaults, Dilithium modulus and FSM state type for poly_div2k
package poly_div2k_pkg;

  localparam int DEF_WIDTH = 24;
  localparam int DEF_LANES = 4;
  localparam int DEF_KMAX  = 8;
  localparam int DIL_Q     = 8380417;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/poly_div2k_lane.sv
// rtl/poly_div2k_lane.sv - one modular halving step: x/2 mod q for odd q, plain shift otherwise
module poly_div2k_lane #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic             q_odd_i,
  input  logic [WIDTH:0]   half_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH:0] sum_w;
  logic           unused_carry;

  // For odd q and odd x, (x-1)/2 + (q+1)/2 == (x+q)/2, which is x * 2^-1 mod q.
  assign sum_w        = {2'b00, x_i[WIDTH-1:1]} + half_i;
  assign unused_carry = sum_w[WIDTH];
  assign y_o          = (q_odd_i && x_i[0]) ? sum_w[WIDTH-1:0] : (x_i >> 1);

endmodule

// File: rtl/poly_div2k.sv
// rtl/poly_div2k.sv - batch multiply of LANES coefficients by 2^-k mod q, one halving per cycle
// Optional input reduction x >= q -> x - q at accept when POLY_DIV2K_IN_REDUCE_EN is defined.
module poly_div2k
  import poly_div2k_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int LANES = DEF_LANES,
  parameter  int KMAX  = DEF_KMAX,
  localparam int KW    = $clog2(KMAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0]       in_q,
  input  logic [KW-1:0]          in_k,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   busy
);

  state_t                 state_q, state_d;
  logic [KW-1:0]          cnt_q, cnt_d;
  logic [LANES*WIDTH-1:0] work_q, work_d;
  logic                   q_odd_q, q_odd_d;
  logic [WIDTH:0]         half_q, half_d;

  logic [LANES*WIDTH-1:0] step_w;
  logic [LANES*WIDTH-1:0] capt_w;
  logic [KW-1:0]          k_sat_w;

  assign k_sat_w = (in_k > KW'(KMAX)) ? KW'(KMAX) : in_k;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    poly_div2k_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .x_i     (work_q[i*WIDTH +: WIDTH]),
      .q_odd_i (q_odd_q),
      .half_i  (half_q),
      .y_o     (step_w[i*WIDTH +: WIDTH])
    );

`ifdef POLY_DIV2K_IN_REDUCE_EN
    assign capt_w[i*WIDTH +: WIDTH] = (in_data[i*WIDTH +: WIDTH] >= in_q)
                                      ? (in_data[i*WIDTH +: WIDTH] - in_q)
                                      : in_data[i*WIDTH +: WIDTH];
`else
    assign capt_w[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    q_odd_d = q_odd_q;
    half_d  = half_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = capt_w;
          q_odd_d = in_q[0];
          half_d  = ({1'b0, in_q} + (WIDTH+1)'(1)) >> 1;
          cnt_d   = k_sat_w;
          state_d = (k_sat_w == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        work_d = step_w;
        cnt_d  = cnt_q - KW'(1);
        if (cnt_q == KW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      q_odd_q <= 1'b0;
      half_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      q_odd_q <= q_odd_d;
      half_q  <= half_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_poly_div2k.sv
// tb/tb_poly_div2k.sv - scoreboard bench for poly_div2k against a modular-inverse reference model
module tb_poly_div2k;

  localparam int W     = 24;
  localparam int L     = 4;
  localparam int KM    = 8;
  localparam int KW    = $clog2(KM + 1);
  localparam int LW    = L * W;
  localparam int DQ    = 8380417;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] in_data = '0;
  logic [W-1:0]  in_q = '0;
  logic [KW-1:0] in_k = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] out_data;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [LW-1:0] exp_q[$];
  int            lat_q[$];
  int            acc_q[$];
  logic [LW-1:0] cur_exp;
  int            cur_lat;
  int            acc_t;
  bit            seen_valid = 1'b0;

  poly_div2k #(.WIDTH(W), .LANES(L), .KMAX(KM)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_q      (in_q),
    .in_k      (in_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // x * 2^-k mod q via repeated multiplication by the inverse of 2; even q degenerates to a shift.
  function automatic longint ref_lane(input longint x_in, input longint q, input int k);
    longint x, r, inv;
    int ke;
    x  = x_in;
    ke = (k > KM) ? KM : k;
`ifdef POLY_DIV2K_IN_REDUCE_EN
    if (x >= q) x = x - q;
`endif
    if (q % 2 == 0) return x >> ke;
    inv = (q + 1) / 2;
    r   = x % q;
    for (int i = 0; i < ke; i++) r = (r * inv) % q;
    return r;
  endfunction

  function automatic logic [LW-1:0] ref_vec(input logic [LW-1:0] d, input logic [W-1:0] q, input int k);
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < L; i++)
      v[i*W +: W] = W'(ref_lane(longint'(d[i*W +: W]), longint'(q), k));
    return v;
  endfunction

  function automatic logic [LW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [LW-1:0] v;
    v = '0;
    v[0*W +: W] = W'(a);
    v[1*W +: W] = W'(b);
    v[2*W +: W] = W'(c);
    v[3*W +: W] = W'(d);
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      seen_valid = 1'b0;
      acc_q.delete();
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          if (exp_q.size() == 0 || acc_q.size() == 0 || lat_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out_valid: got out_valid=1 want no pending batch (cycle %0d)", cyc);
            cur_exp = out_data;
          end else begin
            cur_exp = exp_q.pop_front();
            cur_lat = lat_q.pop_front();
            acc_t   = acc_q.pop_front();
            chk("latency", 128'(cyc - acc_t), 128'(cur_lat));
            chk("out_data", 128'(out_data), 128'(cur_exp));
          end
        end else begin
          chk("out_data_hold", 128'(out_data), 128'(cur_exp));
        end
        chk("busy_in_done", 128'(busy), 128'(1));
        chk("in_ready_in_done", 128'(in_ready), 128'(0));
        if (out_ready) seen_valid = 1'b0;
      end
    end
  end

  task automatic issue(input logic [LW-1:0] d, input logic [W-1:0] q, input int k, input logic [LW-1:0] e);
    int n;
    exp_q.push_back(e);
    lat_q.push_back(((k > KM) ? KM : k) + 1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    in_q     = q;
    in_k     = KW'(k);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom};
    in_q     = W'($urandom);
    in_k     = KW'($urandom);
  endtask

  task automatic drain(input int hold);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk("result_timeout", 128'(out_valid), 128'(1));
    repeat (hold) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_hs", 128'(in_ready), 128'(1));
    chk("busy_after_hs", 128'(busy), 128'(0));
  endtask

  task automatic send(input logic [LW-1:0] d, input logic [W-1:0] q, input int k, input logic [LW-1:0] e, input int hold);
    issue(d, q, k, e);
    drain(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] d;
    logic [W-1:0]  q;
    int            k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    send(pack4(3, 4, 0, 8380416), W'(DQ), 1, pack4(4190210, 2, 0, 4190208), 0);
    send(pack4(1, 1, 1, 1), W'(DQ), 8, pack4(8347681, 8347681, 8347681, 8347681), 1);
    send(pack4(7, 9, 11, 13), W'(DQ), 0, pack4(7, 9, 11, 13), 0);
    d = {$urandom, $urandom, $urandom};
    for (int i = 0; i < L; i++) d[i*W +: W] = W'($urandom % DQ);
    send(d, W'(DQ), 15, ref_vec(d, W'(DQ), 8), 0);
    send(pack4(5, 6, 7, 15), W'(16), 1, pack4(2, 3, 3, 7), 0);
`ifdef POLY_DIV2K_IN_REDUCE_EN
    send(pack4(8380422, 8380417, 2 * DQ - 1, 1), W'(DQ), 1, pack4(4190211, 0, 4190208, 4190209), 0);
`endif

    send(pack4(100, 200, 300, 401), W'(DQ), 3, ref_vec(pack4(100, 200, 300, 401), W'(DQ), 3), 5);

    issue(pack4(1, 2, 3, 4), W'(DQ), 8, ref_vec(pack4(1, 2, 3, 4), W'(DQ), 8));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    chk("rst_run_in_ready", 128'(in_ready), 128'(1));
    chk("rst_run_out_valid", 128'(out_valid), 128'(0));
    chk("rst_run_busy", 128'(busy), 128'(0));
    repeat (15) @(posedge clk);
    #1 chk("no_stale_valid", 128'(out_valid), 128'(0));

    for (int t = 0; t < 40; t++) begin
      if (t % 4 == 3) q = W'($urandom_range(2, (1 << W) - 2)) & ~W'(1);
      else            q = W'($urandom_range(3, (1 << W) - 1)) | W'(1);
      for (int i = 0; i < L; i++) d[i*W +: W] = W'($urandom % q);
      k = $urandom_range(0, 15);
      send(d, q, k, ref_vec(d, q, k), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/poly_div2k.md
POLY_DIV2K -- requirements
Module: poly_div2k

Interface
REQ-001 SHALL have parameter WIDTH, default 24, coefficient and modulus width in bits.
REQ-002 SHALL have parameter LANES, default 4, coefficients processed in parallel.
REQ-003 SHALL have parameter KMAX, default 8, maximum halvings per batch; KW = clog2(KMAX+1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  a batch is presented.
REQ-007 SHALL have port in_ready  output  1  the block accepts a batch this cycle.
REQ-008 SHALL have port in_data  input  LANES*WIDTH  coefficients; lane i is bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port in_q  input  WIDTH  modulus, sampled at accept.
REQ-010 SHALL have port in_k  input  KW  halving count, sampled at accept.
REQ-011 SHALL have port out_valid  output  1  result is held on out_data.
REQ-012 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-013 SHALL have port out_data  output  LANES*WIDTH  x * 2^-k mod q per lane, same lane packing.
REQ-014 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-015 Halving step per lane: if q[0]=1 and x[0]=1, result = (x>>1) + (q+1)/2; otherwise result = x>>1.
REQ-016 Step arithmetic SHALL use WIDTH+1 bits, truncated to WIDTH; (q+1)/2 is computed once at accept, in WIDTH+1 bits.
REQ-017 FSM states: IDLE, RUN, DONE. in_ready = 1 only in IDLE.
REQ-018 IDLE with in_valid: capture in_data, in_q and min(in_k, KMAX); go to RUN with cnt = k, or to DONE if k = 0.
REQ-019 RUN: apply one step to all lanes per cycle and decrement cnt; go to DONE on the cycle cnt goes 1 -> 0.
REQ-020 DONE: out_valid = 1; out_data SHALL stay stable until out_ready; with out_ready, go to IDLE on the next edge.
REQ-021 Latency: out_valid rises exactly k+1 cycles after the accept edge (k = 0 gives 1 cycle); no overlap of batches.
REQ-022 Changes on in_* after accept SHALL have no effect on the batch in flight.
REQ-023 If in_q is even, every step is a plain shift (no modular correction); no error is flagged.
REQ-024 out_data in IDLE and RUN SHALL be the working register; consumers SHALL qualify with out_valid.

Reset
REQ-025 rst SHALL force: state IDLE, in_ready 1, out_valid 0, busy 0, cnt 0, working and out_data registers 0, stored q 0.
REQ-026 rst during RUN or DONE SHALL discard the batch; no out_valid is issued for it.
REQ-027 rst has priority over in_valid and out_ready in the same cycle.

Configuration
REQ-028 Macro POLY_DIV2K_IN_REDUCE_EN defined: at accept, each lane with x >= in_q SHALL be replaced by x - in_q (one conditional subtract), so inputs in [0, 2q) yield outputs in [0, q).
REQ-029 Macro undefined: lanes are captured unmodified; inputs are required to be in [0, q) for outputs in [0, q).

Structure
REQ-030 Package poly_div2k_pkg SHALL hold the default WIDTH/LANES/KMAX, the Dilithium constant Q = 8380417, and the FSM state enum.
REQ-031 Sub-module poly_div2k_lane SHALL implement the combinational single halving step of REQ-015/016; it is instantiated LANES times.

Verification
REQ-032 q = 8380417, k = 1, lanes {3, 4, 0, 8380416} -> out {4190210, 2, 0, 4190208}, 2 cycles after accept.
REQ-033 q = 8380417, k = 8, lane x = 1 -> 8347681 (= 2^-8 mod q), out_valid 9 cycles after accept.
REQ-034 k = 0, lanes {7, 9, 11, 13} -> identical out_data, 1 cycle after accept; in_k = 15 with KMAX = 8 behaves as k = 8.
REQ-035 out_ready held low for 5 cycles in DONE -> out_data stable, in_ready 0, busy 1; in IDLE the cycle after the handshake.
REQ-036 rst pulsed in the third RUN cycle -> next cycle IDLE, out_valid 0, in_ready 1; no stale output later.
REQ-037 POLY_DIV2K_IN_REDUCE_EN on, q = 8380417, k = 1, x = 8380422 -> 4190211; q = 16 even, k = 1, x = 5 -> 2.
